// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, IO page map, load metadata.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  // Encoding that never names an access; used as the idle/reset load code.
  localparam logic [2:0] F3_NONE = 3'b011;

  // IO regions are matched on addr[31:12].
  localparam logic [19:0] PAGE_LEDR   = 20'h1_0000;
  localparam logic [19:0] PAGE_LEDG   = 20'h1_0001;
  localparam logic [19:0] PAGE_HEX_LO = 20'h1_0002;
  localparam logic [19:0] PAGE_HEX_HI = 20'h1_0003;
  localparam logic [19:0] PAGE_LCD    = 20'h1_0004;
  localparam logic [19:0] PAGE_SW     = 20'h1_0010;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_DMEM = 2'd1,
    REG_IO   = 2'd2
  } region_e;

  // What the load pipeline stage remembers about the access sampled at the edge.
  typedef struct packed {
    logic [2:0] funct3;
    region_e    region;
    logic [1:0] off;
  } ld_meta_t;

  // Byte-count mask of a store; non-store encodings write nothing.
  function automatic logic [3:0] store_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B:    return 4'b0001;
      F3_H:    return 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte-wide synchronous RAM bank; read returns the pre-write contents.
module dmem_bank #(
  parameter int unsigned ROW_W = 14
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ROW_W-1:0] addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  localparam int unsigned DEPTH = 1 << ROW_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Single port: write and registered read share the row address.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu.sv
// Load/store unit: byte-banked data memory, memory-mapped IO registers, load extension.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 65536
) (
  input  logic [0:0]  i_clk,
  input  logic [0:0]  i_reset,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [0:0]  i_lsu_wren,
  input  logic [0:0]  i_ctrl_valid,
  input  logic [0:0]  i_ctrl_bubble,
  input  logic [0:0]  i_ctrl_kill,
  output logic [31:0] o_ld_data,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7
);

  localparam int unsigned AW    = $clog2(DMEM_BYTES);
  localparam int unsigned ROW_W = AW - 2;

  logic [1:0]       off;
  logic [4:0]       sh;
  logic [ROW_W-1:0] row_base;
  logic             in_dmem;
  logic             io_word0;
  logic             hit_ledr, hit_ledg, hit_hexlo, hit_hexhi, hit_lcd, hit_sw, hit_io;
  logic             st_commit;
  logic [3:0]       st_mask;
  logic [3:0]       be_dmem;
  logic [3:0]       be_io;
  logic [31:0]      st_rot;

  logic [31:0]      ledr_q, ledg_q, lcd_q;
  logic [6:0]       hex_q [8];
  logic [31:0]      io_rd_word;
  logic [31:0]      io_word_q;
  ld_meta_t         meta_d, meta_q;
  logic [7:0]       bank_rd [4];
  logic [31:0]      dm_word;
  logic [31:0]      raw;

  // Address decode and store qualification.
  always_comb begin
    off       = i_lsu_addr[1:0];
    sh        = {off, 3'b000};
    row_base  = i_lsu_addr[AW-1:2];
    in_dmem   = (i_lsu_addr[31:AW] == '0);
    io_word0  = (i_lsu_addr[11:2] == 10'd0);
    hit_ledr  = io_word0 && (i_lsu_addr[31:12] == PAGE_LEDR);
    hit_ledg  = io_word0 && (i_lsu_addr[31:12] == PAGE_LEDG);
    hit_hexlo = io_word0 && (i_lsu_addr[31:12] == PAGE_HEX_LO);
    hit_hexhi = io_word0 && (i_lsu_addr[31:12] == PAGE_HEX_HI);
    hit_lcd   = io_word0 && (i_lsu_addr[31:12] == PAGE_LCD);
    hit_sw    = io_word0 && (i_lsu_addr[31:12] == PAGE_SW);
    hit_io    = hit_ledr || hit_ledg || hit_hexlo || hit_hexhi || hit_lcd || hit_sw;
    st_commit = i_reset && i_lsu_wren && i_ctrl_valid && !i_ctrl_bubble && !i_ctrl_kill;
    st_mask   = store_mask(i_funct3);
    // DMEM lanes wrap into the next row; IO lanes past byte 3 fall off.
    be_dmem   = 4'({st_mask, st_mask} >> (3'd4 - 3'(off)));
    be_io     = 4'({4'b0000, st_mask} << off);
    // Store byte j lands on lane (off + j) mod 4.
    st_rot    = 32'({i_st_data, i_st_data} >> (6'd32 - 6'(sh)));
  end

  // Four byte banks; lanes below the start offset belong to the following row.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [ROW_W-1:0] row;
    logic             we;
    assign row = row_base + ROW_W'(2'(b) < off);
    assign we  = st_commit && in_dmem && be_dmem[b];

    dmem_bank #(
      .ROW_W (ROW_W)
    ) u_bank (
      .clk     (i_clk),
      .we_i    (we),
      .addr_i  (row),
      .wdata_i (st_rot[8*b +: 8]),
      .rdata_o (bank_rd[b])
    );
  end

  // IO register file with per-lane byte writes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      for (int n = 0; n < 8; n++) begin
        hex_q[n] <= '0;
      end
    end else if (st_commit) begin
      for (int l = 0; l < 4; l++) begin
        if (be_io[l]) begin
          if (hit_ledr)  ledr_q[8*l +: 8] <= st_rot[8*l +: 8];
          if (hit_ledg)  ledg_q[8*l +: 8] <= st_rot[8*l +: 8];
          if (hit_lcd)   lcd_q[8*l +: 8]  <= st_rot[8*l +: 8];
          if (hit_hexlo) hex_q[l]         <= st_rot[8*l +: 7];
          if (hit_hexhi) hex_q[l+4]       <= st_rot[8*l +: 7];
        end
      end
    end
  end

  // Current word of the addressed IO region, before any same-edge store.
  always_comb begin
    io_rd_word = '0;
    if (hit_ledr)       io_rd_word = ledr_q;
    else if (hit_ledg)  io_rd_word = ledg_q;
    else if (hit_lcd)   io_rd_word = lcd_q;
    else if (hit_hexlo) io_rd_word = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
    else if (hit_hexhi) io_rd_word = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
    else if (hit_sw)    io_rd_word = i_io_sw;
  end

  // Load descriptor for the access sampled this edge.
  always_comb begin
    meta_d        = '0;
    meta_d.funct3 = i_funct3;
    meta_d.off    = off;
    meta_d.region = in_dmem ? REG_DMEM : (hit_io ? REG_IO : REG_NONE);
  end

  // Load stage registers; reset forces an access code that yields zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      meta_q    <= '{funct3: F3_NONE, region: REG_NONE, off: 2'b00};
      io_word_q <= '0;
    end else begin
      meta_q    <= meta_d;
      io_word_q <= io_rd_word;
    end
  end

  // Realign the sampled lanes to byte 0 and extend per access size.
  always_comb begin
    dm_word = {bank_rd[3], bank_rd[2], bank_rd[1], bank_rd[0]};
    raw     = '0;
    case (meta_q.region)
      REG_DMEM: raw = 32'({dm_word, dm_word} >> {meta_q.off, 3'b000});
      REG_IO:   raw = 32'({32'h0, io_word_q} >> {meta_q.off, 3'b000});
      default:  raw = '0;
    endcase
    o_ld_data = '0;
    case (meta_q.funct3)
      F3_B:    o_ld_data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    o_ld_data = {{16{raw[15]}}, raw[15:0]};
      F3_W:    o_ld_data = raw;
      F3_BU:   o_ld_data = {24'h0, raw[7:0]};
      F3_HU:   o_ld_data = {16'h0, raw[15:0]};
      default: o_ld_data = '0;
    endcase
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hex_q[0];
  assign o_io_hex1 = hex_q[1];
  assign o_io_hex2 = hex_q[2];
  assign o_io_hex3 = hex_q[3];
  assign o_io_hex4 = hex_q[4];
  assign o_io_hex5 = hex_q[5];
  assign o_io_hex6 = hex_q[6];
  assign o_io_hex7 = hex_q[7];

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads checked against a queue of expected results.
module tb_lsu;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] NOP = 3'b011;
  localparam logic [31:0] A_LEDR  = 32'h1000_0000;
  localparam logic [31:0] A_LEDG  = 32'h1000_1000;
  localparam logic [31:0] A_HEXLO = 32'h1000_2000;
  localparam logic [31:0] A_HEXHI = 32'h1000_3000;
  localparam logic [31:0] A_LCD   = 32'h1000_4000;
  localparam logic [31:0] A_SW    = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  funct3 = NOP;
  logic [31:0] addr = '0;
  logic [31:0] st_data = '0;
  logic        wren = 1'b0;
  logic        valid = 1'b1;
  logic        bubble = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] io_sw = '0;
  logic [31:0] ld_data, ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  lsu #(.DMEM_BYTES(65536)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_funct3      (funct3),
    .i_lsu_addr    (addr),
    .i_st_data     (st_data),
    .i_lsu_wren    (wren),
    .i_ctrl_valid  (valid),
    .i_ctrl_bubble (bubble),
    .i_ctrl_kill   (kill),
    .o_ld_data     (ld_data),
    .i_io_sw       (io_sw),
    .o_io_ledr     (ledr),
    .o_io_ledg     (ledg),
    .o_io_lcd      (lcd),
    .o_io_hex0     (hex0),
    .o_io_hex1     (hex1),
    .o_io_hex2     (hex2),
    .o_io_hex3     (hex3),
    .o_io_hex4     (hex4),
    .o_io_hex5     (hex5),
    .o_io_hex6     (hex6),
    .o_io_hex7     (hex7)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Advance one edge, then compare any load result that became due.
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check(tag_q.pop_front(), ld_data, exp_q.pop_front());
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp, input string tag);
    addr = a; funct3 = f3; wren = 1'b0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    funct3 = NOP;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                       input logic v = 1'b1, input logic b = 1'b0, input logic k = 1'b0);
    addr = a; funct3 = f3; st_data = d; wren = 1'b1; valid = v; bubble = b; kill = k;
    tick();
    wren = 1'b0; valid = 1'b1; bubble = 1'b0; kill = 1'b0; funct3 = NOP;
  endtask

  initial begin
    // Reset state and a blocked store while reset is held
    #12;
    check("rst_ld", ld_data, 32'h0);
    check("rst_ledr", ledr, 32'h0);
    check("rst_hex0", {25'h0, hex0}, 32'h0);
    store(A_LEDR, LW, 32'hFFFF_FFFF);
    check("rst_store_blocked", ledr, 32'h0);
    rst_n = 1'b1;

    // Word store and sized loads
    store(32'h100, LW, 32'hDEAD_BEEF);
    load(32'h100, LW, 32'hDEAD_BEEF, "lw_100");
    load(32'h100, LB, 32'hFFFF_FFEF, "lb_100");
    load(32'h103, LBU, 32'h0000_00DE, "lbu_103");
    load(32'h102, LH, 32'hFFFF_DEAD, "lh_102");
    load(32'h102, LHU, 32'h0000_DEAD, "lhu_102");
    load(32'h100, NOP, 32'h0, "nop_f3_100");

    // Non-store funct3 with wren writes nothing
    store(32'h100, LBU, 32'h0000_0077);
    load(32'h100, LW, 32'hDEAD_BEEF, "bu_store_ignored");

    // Misaligned word across a row boundary; neighbours untouched
    store(32'h200, LB, 32'h0000_005A);
    store(32'h205, LB, 32'h0000_00A5);
    store(32'h201, LW, 32'h1122_3344);
    load(32'h201, LW, 32'h1122_3344, "lw_201");
    load(32'h200, LBU, 32'h0000_005A, "lbu_200");
    load(32'h205, LBU, 32'h0000_00A5, "lbu_205");

    // Halfword wrapping past the top of memory
    store(32'h0000_FFFF, LH, 32'h0000_BEEF);
    load(32'h0000_FFFF, LHU, 32'h0000_BEEF, "lhu_wrap");
    load(32'h0000_0000, LBU, 32'h0000_00BE, "lbu_wrap_0");

    // Store and load of the same address in one cycle returns old data
    store(32'h300, LW, 32'h0102_0304);
    exp_q.push_back(32'h0102_0304);
    tag_q.push_back("rbw_old");
    store(32'h300, LW, 32'hCAFE_F00D);
    load(32'h300, LW, 32'hCAFE_F00D, "rbw_new");

    // Pipeline qualifiers
    store(A_LEDR, LW, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    check("ledr_kill", ledr, 32'h0);
    store(A_LEDR, LW, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    check("ledr_bubble", ledr, 32'h0);
    store(A_LEDR, LW, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check("ledr_invalid", ledr, 32'h0);
    store(A_LEDR, LW, 32'h1234_5678);
    check("ledr_commit", ledr, 32'h1234_5678);
    load(A_LEDR, LW, 32'h1234_5678, "lw_ledr");
    load(A_LEDR + 32'd3, LBU, 32'h0000_0012, "lbu_ledr_3");
    load(A_LEDR + 32'd2, LW, 32'h0000_1234, "lw_ledr_past_lane3");

    // HEX lane mapping and bit 7 discard
    store(A_HEXLO, LW, 32'h7F3F_067F);
    check("hex0", {25'h0, hex0}, 32'h7F);
    check("hex1", {25'h0, hex1}, 32'h06);
    check("hex2", {25'h0, hex2}, 32'h3F);
    check("hex3", {25'h0, hex3}, 32'h7F);
    store(A_HEXHI + 32'd1, LB, 32'h0000_005B);
    check("hex5", {25'h0, hex5}, 32'h5B);
    check("hex4_unchanged", {25'h0, hex4}, 32'h0);
    check("hex6_unchanged", {25'h0, hex6}, 32'h0);
    check("hex7_unchanged", {25'h0, hex7}, 32'h0);
    check("hex0_unchanged", {25'h0, hex0}, 32'h7F);
    store(A_HEXHI, LB, 32'h0000_00FF);
    check("hex4_bit7_drop", {25'h0, hex4}, 32'h7F);
    load(A_HEXHI, LW, 32'h0000_5B7F, "lw_hexhi");
    load(A_HEXLO, LW, 32'h7F3F_067F, "lw_hexlo");

    // Other IO regions, switch input and unmapped reads
    store(A_LEDG + 32'd2, LH, 32'h0000_BEEF);
    check("ledg_upper_half", ledg, 32'hBEEF_0000);
    store(A_LCD + 32'd3, LH, 32'h0000_AABB);
    check("lcd_lane3_only", lcd, 32'hBB00_0000);
    io_sw = 32'h0000_ABCD;
    store(A_SW, LW, 32'h5555_5555);
    load(A_SW, LHU, 32'h0000_ABCD, "lhu_sw");
    load(32'h2000_0000, LW, 32'h0, "lw_unmapped");

    // Asynchronous reset mid-cycle clears outputs without an edge
    load(32'h100, LW, 32'hDEAD_BEEF, "lw_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ld", ld_data, 32'h0);
    check("arst_ledr", ledr, 32'h0);
    check("arst_lcd", lcd, 32'h0);
    check("arst_ledg", ledg, 32'h0);
    check("arst_hex0", {25'h0, hex0}, 32'h0);
    check("arst_hex5", {25'h0, hex5}, 32'h0);
    store(32'h100, LW, 32'h0000_0099);
    store(A_LEDR, LW, 32'h0000_0099);
    check("arst_ledr_blocked", ledr, 32'h0);
    rst_n = 1'b1;
    load(32'h100, LW, 32'hDEAD_BEEF, "dmem_kept_100");
    load(32'h201, LW, 32'h1122_3344, "dmem_kept_201");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DMEM_BYTES, default 65536, is the data-memory size in bytes; it SHALL be a power of two and at most 65536.
REQ-002 i_clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 i_reset  in  1  is the reset; it SHALL be asynchronous and active-low.
REQ-004 i_funct3  in  3  is the access size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-005 i_lsu_addr  in  32  is the byte address.
REQ-006 i_st_data  in  32  is the store data, taken from the low-order bits.
REQ-007 i_lsu_wren  in  1  is the store request.
REQ-008 i_ctrl_valid / i_ctrl_bubble / i_ctrl_kill  in  1 each  are the pipeline qualifiers.
REQ-009 o_ld_data  out  32  is the registered, extended load data.
REQ-010 i_io_sw  in  32  is the switch input.
REQ-011 o_io_ledr, o_io_ledg, o_io_lcd  out  32 each, and o_io_hex0..o_io_hex7  out  7 each, are the output-peripheral registers.

Function
REQ-012 Address map SHALL be:
- DMEM: 0x0000_0000 + [0, DMEM_BYTES).
- LEDR: 0x1000_0000.
- LEDG: 0x1000_1000.
- HEX0-3: 0x1000_2000.
- HEX4-7: 0x1000_3000.
- LCD: 0x1000_4000.
- SW: 0x1001_0000.
- Each IO region SHALL decode on addr[31:12] and be 4 bytes wide; addr[1:0] SHALL select the byte lane.
REQ-013 A store SHALL commit only when i_lsu_wren & i_ctrl_valid & !i_ctrl_bubble & !i_ctrl_kill, at the rising clock edge.
REQ-014 SB SHALL write 1 byte, SH 2 bytes, SW 4 bytes, at addr, addr+1, ... within the same region. Other funct3 values with wren SHALL write nothing.
REQ-015 DMEM SHALL be byte-addressable: four byte banks indexed by (addr+k)>>2. Any alignment SHALL be supported, including accesses spanning a word boundary; addresses SHALL wrap modulo DMEM_BYTES.
REQ-016 The HEX word SHALL map o_io_hexN[6:0] to bits [6:0], [14:8], [22:16], [30:24] for N = 0..3 (4..7 at 0x1000_3000). Bit 7 of each lane SHALL be discarded on write and read as 0.
REQ-017 Stores to SW, unmapped addresses, or IO lanes beyond byte 3 SHALL be ignored.
REQ-018 Loads SHALL have one-cycle latency: the address and funct3 sampled at edge k SHALL produce o_ld_data valid after edge k; o_ld_data SHALL hold until the next edge.
REQ-019 o_ld_data SHALL update every cycle regardless of the qualifiers; the caller decides usage.
REQ-020 Extension rules:
- LB/LH SHALL sign-extend.
- LBU/LHU SHALL zero-extend.
- LW SHALL return 4 bytes.
- Any other funct3 SHALL return 0.
REQ-021 IO registers SHALL read back their current value. SW SHALL return i_io_sw, sampled at the load edge. Unmapped reads SHALL return 0.
REQ-022 Store and load to the same address in one cycle: the load SHALL return the old data (read-before-write).
REQ-023 o_io_* SHALL be driven directly from their registers, with no combinational path from inputs.

Reset
REQ-024 While i_reset=0, o_ld_data and all o_io_* outputs SHALL be 0, and stores SHALL be blocked.
REQ-025 DMEM contents SHALL NOT be reset.
REQ-026 Reset asserted mid-operation SHALL clear the registers immediately, without waiting for a clock edge; a store at that edge SHALL be dropped.

Structure
REQ-027 A shared package SHALL hold the funct3 encodings and IO base-address constants.
REQ-028 Sub-module dmem_bank SHALL implement one synchronous byte-wide RAM bank and be instantiated 4×. The IO register file and the load-extension logic SHALL stay in lsu.

Verification
REQ-029 SW 0xDEADBEEF to 0x100, then LW 0x100 -> o_ld_data=0xDEADBEEF one cycle later; LB 0x100 -> 0xFFFFFFEF; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD.
REQ-030 Misaligned word: SW 0x11223344 to 0x201, then LW 0x201 -> 0x11223344. The bytes at 0x200 and 0x205 SHALL remain unchanged.
REQ-031 Qualifiers: SW to LEDR with i_ctrl_kill=1, with i_ctrl_bubble=1, and with i_ctrl_valid=0 -> o_io_ledr stays 0 in each case. The same store fully qualified -> o_io_ledr updates after the edge.
REQ-032 HEX mapping: SW 0x7F3F067F to 0x1000_2000 -> hex0=0x7F, hex1=0x06, hex2=0x3F, hex3=0x7F. SB 0x5B to 0x1000_3001 -> hex5=0x5B, other HEX digits unchanged.
REQ-033 Reads: i_io_sw=0x0000_ABCD, LHU 0x1001_0000 -> 0x0000ABCD; LW 0x2000_0000 -> 0.
REQ-034 Reset: assert i_reset=0 asynchronously mid-cycle after LEDR/LCD writes -> all IO outputs and o_ld_data read 0 immediately. DMEM data written before reset SHALL still read back after reset is released.
